// File: rtl/mtl1_pkg.sv
// Shared definitions for the terminal-path blocks.
//   CLK_HZ / UART_BAUD : internal oscillator and serial line rates
//   UART_CLKS_PER_BIT  : clocks per serial bit, rounded to nearest
//   rx_state_e         : receive deframer FSM states
package mtl1_pkg;

  localparam int CLK_HZ            = 44_330_000;
  localparam int UART_BAUD         = 115200;
  localparam int UART_CLKS_PER_BIT = (CLK_HZ + UART_BAUD / 2) / UART_BAUD;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of the receive front end.
//   i_rd, i_clear_err          : driven by the consumer (master)
//   o_DATA, o_rx_valid, flags  : driven by uart_rx_fifo (slave)
//   dbg_state, dbg_push        : deframer state and push strobe, observation only
//
// Handshake: o_rx_valid is the valid, i_rd is the ready/pop. A byte transfers
// at a rising clk edge where both are high; o_DATA is the byte that moves.
// i_rd while o_rx_valid is low is ignored. o_DATA and o_rx_valid show the next
// head from the cycle after the transfer.
interface uart_rx_fifo_if;
  import mtl1_pkg::*;

  logic       i_rd;
  logic       i_clear_err;
  logic [7:0] o_DATA;
  logic       o_rx_valid;
  logic       o_rx_full;
  logic       o_overrun;
  logic       o_framing_err;
  rx_state_e  dbg_state;
  logic       dbg_push;

  modport slave (
    input  i_rd, i_clear_err,
    output o_DATA, o_rx_valid, o_rx_full, o_overrun, o_framing_err,
    output dbg_state, dbg_push
  );

  modport master (
    output i_rd, i_clear_err,
    input  o_DATA, o_rx_valid, o_rx_full, o_overrun, o_framing_err,
    input  dbg_state, dbg_push
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : push request
//   rd_en         : pop strobe; ignored while empty
//   rd_data       : word at the read pointer (valid while !empty)
//   empty, full   : occupancy status
//   wr_drop       : a push was refused because the FIFO was full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when it coincides with a pop.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign wr_drop = wr_en && !do_wr;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a first-word-fall-through receive buffer.
//   clk, reset  : oscillator clock, synchronous active-high reset
//   i_UART_TX   : asynchronous serial line, idle high
//   bus (slave) : pop strobe, error clear, head byte, valid/full and
//                 sticky overrun/framing flags, deframer debug state
module uart_rx_fifo
  import mtl1_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_UART_TX,
  uart_rx_fifo_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [1:0]    sync_vld;
  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push_q;
  logic          ferr;
  logic          ovr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b0;
      sync_vld <= 2'b00;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      push_q   <= 1'b0;
      ferr     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      sync1    <= i_UART_TX;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      // The edge detector only arms once sync2 carries a real line sample;
      // a line already low when reset releases never looks like a new edge.
      prev     <= sync2 & sync_vld[1];
      push_q   <= 1'b0;

      // Clear first so a same-cycle error below takes priority.
      if (bus.i_clear_err) begin
        ferr <= 1'b0;
        ovr  <= 1'b0;
      end
      if (fifo_drop) ovr <= 1'b1;

      case (state)
        RX_IDLE: begin
          if (prev && !sync2) begin
            state <= RX_START;
            cnt   <= HALF_BIT;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (sync2) begin
              state <= RX_IDLE;   // too short to be a start bit
            end else begin
              cnt     <= FULL_BIT;
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg   <= {sync2, shreg[7:1]};
            cnt     <= FULL_BIT;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            if (sync2) begin
              push_q <= 1'b1;     // shreg holds the byte until the next frame
              state  <= RX_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= RX_BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_BREAK: begin
          if (sync2) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (shreg),
    .rd_en   (bus.i_rd),
    .rd_data (bus.o_DATA),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .wr_drop (fifo_drop)
  );

  assign bus.o_rx_valid    = !fifo_empty;
  assign bus.o_rx_full     = fifo_full;
  assign bus.o_overrun     = ovr;
  assign bus.o_framing_err = ferr;
  assign bus.dbg_state     = state;
  assign bus.dbg_push      = push_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with 16 clocks per bit and an 8-byte buffer.
// The reference model is a queue holding what the buffer should contain;
// a monitor pops it on every read strobe and compares the presented byte.
module tb_uart_rx_fifo;
  import mtl1_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic line;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_UART_TX (line),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  bit         exp_ovr;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer model: a received byte is kept if there is room or a pop
  // frees a slot in the same cycle; otherwise it is lost and overrun is set.
  task automatic model_push(input logic [7:0] b, input bit pop_same);
    if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (bus.i_rd && !reset) begin
      if (exp_q.size() == 0) begin
        check("pop_on_empty_valid", bus.o_rx_valid, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("pop_valid", bus.o_rx_valid, 1);
        check("pop_data", bus.o_DATA, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame, one bit per CPB clocks, changing at negedges.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit clr_at_stop,
                            input bit rd_on_push, input bit abort);
    for (int k = 0; k < 10; k++) begin
      line = (k == 0) ? 1'b0 : (k == 9) ? stop_v : b[k-1];
      for (int j = 0; j < CPB; j++) begin
        if (k == 9 && clr_at_stop) bus.i_clear_err = (j >= 8 && j <= 10);
        if (k == 9 && rd_on_push) bus.i_rd = bus.dbg_push;
        if (abort) begin
          reset = (k == 4 && j == 8);
          if (k == 4 && j == 8) begin
            exp_q.delete();
            exp_ovr = 1'b0;
          end
        end
        @(negedge clk);
      end
      if (abort && k == 4) begin
        reset = 1'b0;
        return;
      end
    end
    bus.i_rd        = 1'b0;
    bus.i_clear_err = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    model_push(b, 1'b0);
    send_frame(b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_rd = 1'b1;
      @(negedge clk);
      bus.i_rd = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic clear_err();
    bus.i_clear_err = 1'b1;
    @(negedge clk);
    bus.i_clear_err = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    reset           = 1'b1;
    line            = 1'b1;
    bus.i_rd        = 1'b0;
    bus.i_clear_err = 1'b0;
    exp_ovr         = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(4);

    // Reset state
    check("rst_valid", bus.o_rx_valid, 0);
    check("rst_full", bus.o_rx_full, 0);
    check("rst_overrun", bus.o_overrun, 0);
    check("rst_framing", bus.o_framing_err, 0);
    check("rst_state", bus.dbg_state, RX_IDLE);

    // Single byte
    send(8'h55);
    idle(2);
    check("t1_valid", bus.o_rx_valid, 1);
    check("t1_data", bus.o_DATA, 8'h55);
    pop_n(1);
    check("t1_valid_after_pop", bus.o_rx_valid, 0);

    // Back-to-back frames, then fill to full
    send(8'h00);
    send(8'hFF);
    send(8'hA5);
    check("t2_valid", bus.o_rx_valid, 1);
    pop_n(3);
    check("t2_empty", bus.o_rx_valid, 0);
    for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 255)));
    check("t2_full", bus.o_rx_full, 1);
    check("t2_no_overrun", bus.o_overrun, 0);
    pop_n(DEPTH);
    check("t2_drained", bus.o_rx_valid, 0);

    // Overrun: ninth byte lost
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("t3_overrun", bus.o_overrun, exp_ovr);
    check("t3_full", bus.o_rx_full, 1);
    pop_n(DEPTH);
    check("t3_drained", bus.o_rx_valid, 0);
    clear_err();
    check("t3_overrun_cleared", bus.o_overrun, 0);

    // Ninth push coinciding with a pop is kept
    for (int i = 1; i <= 8; i++) send(8'(i));
    model_push(8'h09, 1'b1);
    send_frame(8'h09, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3b_no_overrun", bus.o_overrun, 0);
    check("t3b_full", bus.o_rx_full, 1);
    pop_n(DEPTH);
    check("t3b_drained", bus.o_rx_valid, 0);

    // Short glitch is not a start bit
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(40);
    check("t4_glitch_valid", bus.o_rx_valid, 0);
    check("t4_glitch_ferr", bus.o_framing_err, 0);
    check("t4_glitch_state", bus.dbg_state, RX_IDLE);

    // Bad stop bit, line held low afterwards
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("t4_break_state", bus.dbg_state, RX_BREAK);
    check("t4_ferr", bus.o_framing_err, 1);
    check("t4_no_push", bus.o_rx_valid, 0);
    line = 1'b1;
    idle(10);
    check("t4_back_idle", bus.dbg_state, RX_IDLE);
    clear_err();
    check("t4_ferr_cleared", bus.o_framing_err, 0);
    idle(20);
    check("t4_ferr_once", bus.o_framing_err, 0);

    // Reset mid-frame with a byte buffered and an error pending
    send(8'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    line = 1'b1;
    idle(10);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    line = 1'b1;
    idle(3);
    check("t5_rst_valid", bus.o_rx_valid, 0);
    check("t5_rst_ferr", bus.o_framing_err, 0);
    check("t5_rst_ovr", bus.o_overrun, 0);
    check("t5_rst_state", bus.dbg_state, RX_IDLE);

    // Line low across reset does not start a frame
    line = 1'b0;
    idle(5);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(40);
    check("t5_low_state", bus.dbg_state, RX_IDLE);
    check("t5_low_valid", bus.o_rx_valid, 0);
    line = 1'b1;
    idle(20);
    send(8'h3C);
    check("t5_data", bus.o_DATA, 8'h3C);
    pop_n(1);

    // Clear in the same cycle as a framing error: set wins
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    line = 1'b1;
    idle(5);
    check("t6_set_wins", bus.o_framing_err, 1);
    clear_err();
    check("t6_cleared", bus.o_framing_err, 0);
    pop_n(3);
    check("t6_empty_pop_valid", bus.o_rx_valid, 0);
    b = 8'($urandom_range(0, 255));
    send(b);
    pop_n(1);
    check("t6_after_empty_pops", bus.o_rx_valid, 0);

    // Random frames with random read bursts
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom_range(0, 255)));
      check("rnd_full", bus.o_rx_full, (exp_q.size() == DEPTH));
      pop_n($urandom_range(0, 2));
      idle($urandom_range(0, 3));
    end
    check("rnd_overrun", bus.o_overrun, exp_ovr);
    pop_n(exp_q.size());
    check("rnd_drained", bus.o_rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
